fifo_storage: RTL and testbench
===============================

# fifo_storage

Data path of the shift-register FIFO. It consumes the occupancy pointer `pc` and the forwarded `push_out` strobe from the FIFO pointer controller. It holds up to `depth-1` words of `bits` width and presents the oldest word on `Dout` with a one-cycle valid pulse. It also derives the `full`, `empty` and `pndng` status flags seen by the producer and consumer.

## Interface
- `bits`, 4: data word width.
- `depth`, 8: storage entries; usable capacity is `depth-1`, matching the controller's saturation at `depth-1`.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `push` input 1: write strobe, driven from the controller's `push_out`.
- `pop` input 1: read request from the consumer.
- `Din` input `bits`: write data.
- `pc` input `$clog2(depth)+1`: current occupancy from the controller, pre-edge value.
- `Dout` output `bits`: registered read data.
- `valid` output 1: one-cycle pulse; `Dout` was updated by an accepted pop.
- `full` output 1: combinational, `pc == depth-1`.
- `empty` output 1: combinational, `pc == 0`.
- `pndng` output 1: combinational, `!empty`.
- `overflow` output 1: sticky error flag (see Configuration).
- `underflow` output 1: sticky error flag (see Configuration).

## Operation
- Storage is `mem[0..depth-1]`. Index 0 holds the newest word; index `pc-1` holds the oldest.
- **Accepted push**: `push && (!full || pop)`. Every entry shifts up by one (`mem[i] <= mem[i-1]`) and `mem[0] <= Din`. Entry `depth-1` is discarded.
- **Accepted pop**: `pop && !empty`. Then `Dout <= mem[pc-1]`, read before any shift in the same edge, and `valid <= 1`. Otherwise `valid <= 0` and `Dout` holds its value.
- **Simultaneous push and pop, not empty**: both are accepted. The oldest word is read from pre-shift `mem[pc-1]` and the new word enters at `mem[0]`. Occupancy is unchanged, consistent with the controller holding `pc`.
- **Push and pop on empty**: the push is accepted and the pop is ignored. No `valid`, and `Dout` holds.
- **Push while full, no pop**: dropped. Storage is unchanged.
- **Pop while empty**: ignored.
- The block never modifies `pc`. It trusts the controller's count.
- **Reset (low, any time, asynchronous)**: all `mem` entries cleared to 0, `Dout = 0`, `valid = 0`, `overflow = 0`, `underflow = 0`. A reset mid-transfer discards all contents. Status outputs follow `pc` combinationally.

## Timing
- Write-to-readable latency: a word pushed at edge N can be popped at edge N+1, when `pc` reflects it.
- Read latency: a pop accepted at edge N gives `Dout` and `valid` stable after edge N, for one cycle.
- Back-to-back pops on consecutive edges give consecutive words with `valid` held high. Each cycle still counts as a separate pulse.
- Flags are combinational from `pc` and add zero cycles of latency.

## Configuration
- Macro: `FIFO_ERR_FLAGS_EN`.
- **Defined**: `overflow` is set on a push while full with no pop. `underflow` is set on a pop while empty. Both stay sticky until reset.
- **Undefined**: both ports are tied to 0 and the error logic is not synthesised. The ports remain in the interface so the bench is unchanged.

## Structure
- Shared package `fifo_pkg`:
  - localparam helper for the pointer width, `$clog2(depth)+1`.
  - Reset values for `Dout` and the flags.
- One sub-module is natural: `fifo_shift_reg`. It holds the `depth`-entry shifting array with shift-enable and clear, and exposes all entries for the read mux.
- The top level holds the read mux, the `Dout`/`valid` registers, the flags and the error logic.

## Test plan
All scenarios use `bits=4`, `depth=8`, with a controller model driving `pc`.
- **Reset**: apply reset mid-run with 3 entries stored -> `Dout=0`, `valid=0`, `mem` all 0; with `pc=0`, `empty=1` and `pndng=0`.
- **Ordering**: push 0x1, 0x2, 0x3, then pop three times -> `Dout` is 0x1, 0x2, 0x3 on consecutive cycles and `valid` is high for 3 cycles.
- **Fill**: push 7 words, 0x1 through 0x7 -> `full=1`. An 8th push of 0x8 is dropped, and popping 7 times returns 0x1..0x7. With `FIFO_ERR_FLAGS_EN`, `overflow=1`.
- **Simultaneous push/pop**: with `pc=2` holding 0xA (old) and 0xB, push 0xC with pop -> `Dout=0xA`, and the remaining order is 0xB, 0xC.
- **Empty pop**: pop with `pc=0` -> `valid=0` and `Dout` unchanged. With the macro, `underflow=1`; without it, `underflow=0`.
- **Push and pop on empty**: push 0x5 with pop at `pc=0` -> no `valid`. The next pop returns 0x5.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the shift-register FIFO data path.
//   ptr_width()      width of the occupancy pointer, $clog2(depth)+1
//   *_RST            reset values for the registered read data and the flags
package fifo_pkg;

   // The extra bit lets the pointer represent a count equal to depth.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   localparam logic DOUT_RST_BIT  = 1'b0;
   localparam logic VALID_RST     = 1'b0;
   localparam logic OVERFLOW_RST  = 1'b0;
   localparam logic UNDERFLOW_RST = 1'b0;

endpackage

// File: rtl/fifo_shift_reg.sv
// fifo_shift_reg: depth-entry shifting word array. Entry 0 receives the newest
// word, and the word in entry depth-1 falls off the end on each shift.
//   clk       rising-edge clock
//   reset     asynchronous active-low reset, clears every entry
//   shift_en  shift all entries up by one and load din into entry 0
//   clr       synchronous clear of every entry, has priority over shift_en
//   din       word loaded on a shift
//   mem       all entries, exposed for an external read mux
module fifo_shift_reg #(
   parameter int unsigned bits  = 4,
   parameter int unsigned depth = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       shift_en,
   input  logic                       clr,
   input  logic [bits-1:0]            din,
   output logic [depth-1:0][bits-1:0] mem
);

   logic [depth-1:0][bits-1:0] mem_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q <= '0;
      end else if (clr) begin
         mem_q <= '0;
      end else if (shift_en) begin
         mem_q <= {mem_q[depth-2:0], din};
      end
   end

   assign mem = mem_q;

endmodule

// File: rtl/fifo_storage.sv
// fifo_storage: data path of the shift-register FIFO. Stores up to depth-1
// words, presents the oldest word on Dout with a one-cycle valid pulse, and
// derives the status flags from the controller's occupancy count pc.
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   push       write strobe (controller's push_out)
//   pop        read request
//   Din        write data
//   pc         occupancy from the controller, pre-edge value
//   Dout       registered read data
//   valid      one-cycle pulse, Dout updated by an accepted pop
//   full       pc == depth-1
//   empty      pc == 0
//   pndng      !empty
//   overflow   sticky push-while-full error
//   underflow  sticky pop-while-empty error
// Build option: define FIFO_ERR_FLAGS_EN to implement the sticky error flags;
// otherwise overflow and underflow are tied to 0.
module fifo_storage
   import fifo_pkg::*;
#(
   parameter int unsigned bits  = 4,
   parameter int unsigned depth = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [bits-1:0]               Din,
   input  logic [ptr_width(depth)-1:0]   pc,
   output logic [bits-1:0]               Dout,
   output logic                          valid,
   output logic                          full,
   output logic                          empty,
   output logic                          pndng,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int unsigned PcW  = ptr_width(depth);
   localparam int unsigned IdxW = $clog2(depth);

   logic [depth-1:0][bits-1:0] mem;
   logic [bits-1:0]            rd_word;
   logic                       pop_ok;
   logic                       push_ok;
   logic [bits-1:0]            dout_q;
   logic                       valid_q;

   assign empty = (pc == '0);
   assign full  = (pc == PcW'(depth - 1));
   assign pndng = !empty;

   // A pop while full frees a slot in the same edge, so the push still goes in.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop);

   // Oldest word sits at pc-1; only meaningful when pop_ok.
   assign rd_word = mem[IdxW'(pc - PcW'(1))];

   fifo_shift_reg #(
      .bits  (bits),
      .depth (depth)
   ) u_shift_reg (
      .clk      (clk),
      .reset    (reset),
      .shift_en (push_ok),
      .clr      (1'b0),
      .din      (Din),
      .mem      (mem)
   );

   // Read uses pre-shift contents, so simultaneous push/pop returns the true oldest.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout_q  <= {bits{DOUT_RST_BIT}};
         valid_q <= VALID_RST;
      end else begin
         valid_q <= pop_ok;
         if (pop_ok) begin
            dout_q <= rd_word;
         end
      end
   end

   assign Dout  = dout_q;
   assign valid = valid_q;

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q  <= OVERFLOW_RST;
         underflow_q <= UNDERFLOW_RST;
      end else begin
         if (push && full && !pop) begin
            overflow_q <= 1'b1;
         end
         if (pop && empty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = OVERFLOW_RST;
   assign underflow = UNDERFLOW_RST;
`endif

endmodule

// File: tb/tb_fifo_storage.sv
// tb_fifo_storage: scoreboard bench for fifo_storage (bits=4, depth=8).
// The reference is a plain queue of stored words; its size plays the role of
// the pointer controller and drives pc. Expected read words go to a second
// queue that a negedge monitor consumes whenever valid is high.
module tb_fifo_storage;

   localparam int BITS  = 4;
   localparam int DEPTH = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            push;
   logic            pop;
   logic [BITS-1:0] Din;
   logic [3:0]      pc;
   logic [BITS-1:0] Dout;
   logic            valid;
   logic            full;
   logic            empty;
   logic            pndng;
   logic            overflow;
   logic            underflow;

   always #5 clk = ~clk;

   fifo_storage #(
      .bits  (BITS),
      .depth (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .Din       (Din),
      .pc        (pc),
      .Dout      (Dout),
      .valid     (valid),
      .full      (full),
      .empty     (empty),
      .pndng     (pndng),
      .overflow  (overflow),
      .underflow (underflow)
   );

   int              n_cmp  = 0;
   int              n_fail = 0;
   bit              mon_en = 1'b0;
   logic [BITS-1:0] q[$];
   logic [BITS-1:0] exp_q[$];
   logic [BITS-1:0] last_dout;
   logic [BITS-1:0] mon_word;
   bit              m_ovf;
   bit              m_udf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: flags every cycle, read data whenever valid pulses.
   always @(negedge clk) begin
      if (mon_en) begin
         check("full", full, q.size() == DEPTH - 1);
         check("empty", empty, q.size() == 0);
         check("pndng", pndng, q.size() != 0);
         check("overflow", overflow, m_ovf);
         check("underflow", underflow, m_udf);
         if (valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL orphan_valid: got valid=1 Dout=%0h, expected no valid at %0t",
                        Dout, $time);
            end else begin
               mon_word = exp_q.pop_front();
               check("dout", Dout, mon_word);
               last_dout = mon_word;
            end
         end else begin
            check("dout_hold", Dout, last_dout);
         end
         check("valid_missing", exp_q.size(), 0);
      end
   end

   // One clock of stimulus; the model applies its update just after the edge.
   task automatic step(input bit p, input bit po, input logic [BITS-1:0] d);
      int              sz;
      bit              pa;
      bit              pu;
      bit              ovf_n;
      bit              udf_n;
      logic [BITS-1:0] w;
      sz    = q.size();
      push  = p;
      pop   = po;
      Din   = d;
      pa    = po && (sz > 0);
      pu    = p && ((sz < DEPTH - 1) || pa);
      ovf_n = m_ovf;
      udf_n = m_udf;
`ifdef FIFO_ERR_FLAGS_EN
      if (p && !po && sz == DEPTH - 1) ovf_n = 1'b1;
      if (po && sz == 0) udf_n = 1'b1;
`endif
      @(posedge clk);
      #1;
      if (pa) begin
         w = q.pop_front();
         exp_q.push_back(w);
      end
      if (pu) q.push_back(d);
      pc    = 4'(q.size());
      m_ovf = ovf_n;
      m_udf = udf_n;
   endtask

   initial begin
      reset     = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      Din       = '0;
      pc        = '0;
      last_dout = '0;
      m_ovf     = 1'b0;
      m_udf     = 1'b0;

      #12;
      check("rst_dout", Dout, 0);
      check("rst_valid", valid, 0);
      check("rst_empty", empty, 1);
      check("rst_pndng", pndng, 0);
      check("rst_full", full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_underflow", underflow, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Ordering
      step(1, 0, 4'h1);
      step(1, 0, 4'h2);
      step(1, 0, 4'h3);
      repeat (3) step(0, 1, 4'h0);
      step(0, 0, 4'h0);

      // Fill, then a dropped push while full
      for (int i = 1; i <= 7; i++) step(1, 0, 4'(i));
      step(1, 0, 4'h8);
      repeat (7) step(0, 1, 4'h0);
      step(0, 0, 4'h0);

      // Simultaneous push/pop with two stored words
      step(1, 0, 4'hA);
      step(1, 0, 4'hB);
      step(1, 1, 4'hC);
      repeat (2) step(0, 1, 4'h0);
      step(0, 0, 4'h0);

      // Pop on empty, then push+pop on empty
      step(0, 1, 4'h0);
      step(0, 0, 4'h0);
      step(1, 1, 4'h5);
      step(0, 1, 4'h0);
      step(0, 0, 4'h0);

      // Asynchronous reset mid-cycle with three words stored
      step(1, 0, 4'h1);
      step(1, 0, 4'h2);
      step(1, 0, 4'h3);
      mon_en = 1'b0;
      push   = 1'b0;
      pop    = 1'b0;
      #2;
      reset = 1'b0;
      pc    = '0;
      #1;
      check("midrst_dout", Dout, 0);
      check("midrst_valid", valid, 0);
      check("midrst_empty", empty, 1);
      check("midrst_pndng", pndng, 0);
      check("midrst_overflow", overflow, 0);
      check("midrst_underflow", underflow, 0);
      q.delete();
      exp_q.delete();
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
      last_dout = '0;
      @(negedge clk);
      reset = 1'b1;

      // Force pc past the cleared entries: every read must return 0.
      pop = 1'b1;
      for (int k = 3; k >= 1; k--) begin
         pc = 4'(k);
         @(posedge clk);
         #1;
         check("memclr_valid", valid, 1);
         check("memclr_dout", Dout, 0);
      end
      pop = 1'b0;
      pc  = '0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Randomized traffic
      repeat (600) begin
         step(($urandom % 100) < 55, ($urandom % 100) < 50, 4'($urandom));
      end
      while (q.size() > 0) step(0, 1, 4'h0);
      step(0, 0, 4'h0);
      step(0, 0, 4'h0);
      mon_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
